// File: rtl/sram_bus_ctrl_pkg.sv
// sram_bus_pkg: shared constants and types for the SRAM / UART / debug bus
// controller.
//   - Decode addresses for the memory-mapped peripherals.
//   - Request size encoding.
//   - Controller FSM states.
//   - Decode target enum and helper functions.
package sram_bus_pkg;

  localparam logic [31:0] ADDR_UART_DATA = 32'hBFD0_03F8;
  localparam logic [31:0] ADDR_UART_STAT = 32'hBFD0_03FC;
  localparam logic [31:0] ADDR_LED       = 32'hBFD0_0400;
  localparam logic [31:0] ADDR_DPY       = 32'hBFD0_0408;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_BAD  = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    IDLE, SETUP, STROBE, DONE, UWAIT, UPULSE, URESP, ERR
  } state_e;

  typedef enum logic [2:0] {
    TGT_RAM, TGT_UDATA, TGT_USTAT, TGT_LED, TGT_DPY
  } tgt_e;

  // Peripheral addresses are matched exactly; everything else is SRAM.
  function automatic tgt_e decode(input logic [31:0] a);
    tgt_e t;
    case (a)
      ADDR_UART_DATA: t = TGT_UDATA;
      ADDR_UART_STAT: t = TGT_USTAT;
      ADDR_LED:       t = TGT_LED;
      ADDR_DPY:       t = TGT_DPY;
      default:        t = TGT_RAM;
    endcase
    return t;
  endfunction

  // Illegal size code, or an access that does not sit on its natural boundary.
  function automatic logic bad_access(input logic [1:0] sz, input logic [1:0] lo);
    logic b;
    case (size_e'(sz))
      SZ_BYTE: b = 1'b0;
      SZ_HALF: b = lo[0];
      SZ_WORD: b = |lo;
      default: b = 1'b1;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/sram_bus_ctrl_if.sv
// sram_bus_ctrl_if: request/response handshake between a bus master and the
// controller.
//   master : drives req_*, sees req_ready and resp_*.
//   slave  : the controller side.
interface sram_bus_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/sram_lane_align.sv
// sram_lane_align: combinational byte-lane steering for 32-bit SRAM.
//   addr_lo/size/is_unsigned : latched access attributes
//   wdata      -> wdata_rep  : write data replicated onto every lane
//   rdata_raw  -> rdata_ext  : active lane(s) shifted down and extended
//   be_n                     : active-low byte enables
module sram_lane_align
  import sram_bus_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata_raw,
  output logic [3:0]  be_n,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel  = rdata_raw[{addr_lo, 3'b000} +: 8];
    half_sel  = addr_lo[1] ? rdata_raw[31:16] : rdata_raw[15:0];
    be_n      = 4'b0000;
    wdata_rep = wdata;
    rdata_ext = rdata_raw;
    case (size_e'(size))
      SZ_BYTE: begin
        be_n          = 4'b1111;
        be_n[addr_lo] = 1'b0;
        wdata_rep     = {4{wdata[7:0]}};
        rdata_ext     = {{24{~is_unsigned & byte_sel[7]}}, byte_sel};
      end
      SZ_HALF: begin
        be_n      = addr_lo[1] ? 4'b0011 : 4'b1100;
        wdata_rep = {2{wdata[15:0]}};
        rdata_ext = {{16{~is_unsigned & half_sel[15]}}, half_sel};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/sram_bus_ctrl.sv
// sram_bus_ctrl: single-outstanding bus controller for two asynchronous SRAM
// banks, a byte-wide UART sharing the base bank data pins, and LED/7-seg
// debug registers.
//   clk, rst_n            : clock, async active-low reset
//   bus (slave)           : request/response handshake
//   base_ram_* / ext_ram_*: SRAM pins (32-bit data inout)
//   uart_*                : UART strobes and status
//   debug_leds/debug_dpys : debug output registers
module sram_bus_ctrl
  import sram_bus_pkg::*;
#(
  parameter int SRAM_AW     = 20,
  parameter int WAIT_CYCLES = 1,
  parameter int UART_PULSE  = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  sram_bus_ctrl_if.slave     bus,
  inout  wire  [31:0]        base_ram_data,
  output logic [SRAM_AW-1:0] base_ram_addr,
  output logic [3:0]         base_ram_be_n,
  output logic               base_ram_ce_n,
  output logic               base_ram_oe_n,
  output logic               base_ram_we_n,
  inout  wire  [31:0]        ext_ram_data,
  output logic [SRAM_AW-1:0] ext_ram_addr,
  output logic [3:0]         ext_ram_be_n,
  output logic               ext_ram_ce_n,
  output logic               ext_ram_oe_n,
  output logic               ext_ram_we_n,
  output logic               uart_rdn,
  output logic               uart_wrn,
  input  logic               uart_dataready,
  input  logic               uart_tbre,
  input  logic               uart_tsre,
  output logic [15:0]        debug_leds,
  output logic [7:0]         debug_dpys
);

  state_e             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               we_q, we_d;
  logic               uns_q, uns_d;
  logic [1:0]         size_q, size_d;
  logic [1:0]         lo_q, lo_d;
  logic [SRAM_AW-1:0] waddr_q, waddr_d;
  logic               bank_q, bank_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [31:0]        rdata_q, rdata_d;
  logic [15:0]        leds_q, leds_d;
  logic [7:0]         dpys_q, dpys_d;

  logic [3:0]  be_n_c;
  logic [31:0] wdata_rep_c, rdata_ext_c, rdata_raw;

  assign rdata_raw = bank_q ? ext_ram_data : base_ram_data;

  sram_lane_align u_align (
    .addr_lo     (lo_q),
    .size        (size_q),
    .is_unsigned (uns_q),
    .wdata       (wdata_q),
    .rdata_raw   (rdata_raw),
    .be_n        (be_n_c),
    .wdata_rep   (wdata_rep_c),
    .rdata_ext   (rdata_ext_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= '0;
      lo_q    <= '0;
      waddr_q <= '0;
      bank_q  <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      leds_q  <= '0;
      dpys_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      uns_q   <= uns_d;
      size_q  <= size_d;
      lo_q    <= lo_d;
      waddr_q <= waddr_d;
      bank_q  <= bank_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      leds_q  <= leds_d;
      dpys_q  <= dpys_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    uns_d   = uns_q;
    size_d  = size_q;
    lo_d    = lo_q;
    waddr_d = waddr_q;
    bank_d  = bank_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    leds_d  = leds_q;
    dpys_d  = dpys_q;
    case (state_q)
      IDLE: if (bus.req_valid) begin
        // Everything the access needs is captured here; req_* is ignored
        // until the controller is back in IDLE.
        we_d    = bus.req_we;
        uns_d   = bus.req_unsigned;
        size_d  = bus.req_size;
        lo_d    = bus.req_addr[1:0];
        waddr_d = bus.req_addr[SRAM_AW+1:2];
        bank_d  = bus.req_addr[SRAM_AW+2];
        wdata_d = bus.req_wdata;
        rdata_d = '0;
        cnt_d   = '0;
        if (bad_access(bus.req_size, bus.req_addr[1:0])) begin
          state_d = ERR;
        end else begin
          case (decode(bus.req_addr))
            TGT_RAM:   state_d = SETUP;
            TGT_UDATA: state_d = bus.req_we ? UWAIT : UPULSE;
            TGT_USTAT: begin
              rdata_d = {30'b0, uart_dataready, uart_tsre};
              state_d = URESP;
            end
            TGT_LED: begin
              if (bus.req_we) leds_d = bus.req_wdata[15:0];
              rdata_d = {16'b0, leds_q};
              state_d = URESP;
            end
            TGT_DPY: begin
              if (bus.req_we) dpys_d = bus.req_wdata[7:0];
              rdata_d = {24'b0, dpys_q};
              state_d = URESP;
            end
            default: state_d = ERR;
          endcase
        end
      end
      SETUP: begin
        cnt_d   = '0;
        state_d = STROBE;
      end
      STROBE: begin
        if (cnt_q == 4'(WAIT_CYCLES)) begin
          if (!we_q) rdata_d = rdata_ext_c;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      UWAIT: if (uart_tbre) begin
        cnt_d   = '0;
        state_d = UPULSE;
      end
      UPULSE: begin
        if (cnt_q == 4'(UART_PULSE - 1)) begin
          if (!we_q) rdata_d = {24'b0, base_ram_data[7:0]};
          state_d = URESP;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DONE, URESP, ERR: state_d = IDLE;
      default:          state_d = IDLE;
    endcase
  end

  // Pin outputs decode straight from the state register so an asynchronous
  // reset releases every strobe in the same instant. Chip enable covers SETUP
  // and STROBE; DONE releases it while write data is still held.
  logic        ram_sel, bus_hold, strobe, base_drv, ext_drv;
  logic [31:0] base_out;

  always_comb begin
    ram_sel  = (state_q == SETUP) || (state_q == STROBE);
    bus_hold = ram_sel || (state_q == DONE);
    strobe   = (state_q == STROBE);

    base_ram_addr = waddr_q;
    ext_ram_addr  = waddr_q;
    base_ram_ce_n = !(ram_sel && !bank_q);
    ext_ram_ce_n  = !(ram_sel && bank_q);
    base_ram_oe_n = !(strobe && !we_q && !bank_q);
    ext_ram_oe_n  = !(strobe && !we_q && bank_q);
    base_ram_we_n = !(strobe && we_q && !bank_q);
    ext_ram_we_n  = !(strobe && we_q && bank_q);
    base_ram_be_n = (bus_hold && !bank_q) ? be_n_c : 4'b1111;
    ext_ram_be_n  = (bus_hold && bank_q) ? be_n_c : 4'b1111;

    uart_wrn = !((state_q == UPULSE) && we_q);
    uart_rdn = !((state_q == UPULSE) && !we_q);

    // The UART hangs off base_ram_data[7:0]; base bank stays deselected then.
    base_drv = (bus_hold && we_q && !bank_q) || !uart_wrn;
    ext_drv  = bus_hold && we_q && bank_q;
    base_out = !uart_wrn ? {24'b0, wdata_q[7:0]} : wdata_rep_c;

    bus.req_ready  = (state_q == IDLE);
    bus.resp_valid = (state_q == DONE) || (state_q == URESP) || (state_q == ERR);
    bus.resp_err   = (state_q == ERR);
    bus.resp_rdata = (bus.resp_valid && !we_q) ? rdata_q : 32'b0;

    debug_leds = leds_q;
    debug_dpys = dpys_q;
  end

  assign base_ram_data = base_drv ? base_out : 32'hzzzz_zzzz;
  assign ext_ram_data  = ext_drv ? wdata_rep_c : 32'hzzzz_zzzz;

endmodule

// File: tb/tb_sram_bus_ctrl.sv
// Self-checking bench for sram_bus_ctrl (SRAM_AW=20, WAIT_CYCLES=1,
// UART_PULSE=2). Responses are checked by a scoreboard: each request pushes
// its expected rdata/err/latency, the monitor pops on resp_valid.
module tb_sram_bus_ctrl;

  localparam int WAITC = 1;
  localparam int UPUL  = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sram_bus_ctrl_if bus ();

  wire  [31:0] base_ram_data, ext_ram_data;
  logic [19:0] base_ram_addr, ext_ram_addr;
  logic [3:0]  base_ram_be_n, ext_ram_be_n;
  logic        base_ram_ce_n, base_ram_oe_n, base_ram_we_n;
  logic        ext_ram_ce_n, ext_ram_oe_n, ext_ram_we_n;
  logic        uart_rdn, uart_wrn;
  logic        uart_dataready = 1'b0, uart_tbre = 1'b1, uart_tsre = 1'b1;
  logic [7:0]  uart_rx = 8'h00;
  logic [15:0] debug_leds;
  logic [7:0]  debug_dpys;

  sram_bus_ctrl #(.SRAM_AW(20), .WAIT_CYCLES(WAITC), .UART_PULSE(UPUL)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .base_ram_data(base_ram_data), .base_ram_addr(base_ram_addr),
    .base_ram_be_n(base_ram_be_n), .base_ram_ce_n(base_ram_ce_n),
    .base_ram_oe_n(base_ram_oe_n), .base_ram_we_n(base_ram_we_n),
    .ext_ram_data(ext_ram_data), .ext_ram_addr(ext_ram_addr),
    .ext_ram_be_n(ext_ram_be_n), .ext_ram_ce_n(ext_ram_ce_n),
    .ext_ram_oe_n(ext_ram_oe_n), .ext_ram_we_n(ext_ram_we_n),
    .uart_rdn(uart_rdn), .uart_wrn(uart_wrn),
    .uart_dataready(uart_dataready), .uart_tbre(uart_tbre), .uart_tsre(uart_tsre),
    .debug_leds(debug_leds), .debug_dpys(debug_dpys)
  );

  // Small SRAM models (16 words per bank) plus the UART receive byte.
  logic [31:0] bmem [16];
  logic [31:0] emem [16];

  assign base_ram_data = (!base_ram_ce_n && !base_ram_oe_n) ? bmem[base_ram_addr[3:0]] :
                         (!uart_rdn ? {24'h0, uart_rx} : 32'hzzzz_zzzz);
  assign ext_ram_data  = (!ext_ram_ce_n && !ext_ram_oe_n) ? emem[ext_ram_addr[3:0]] : 32'hzzzz_zzzz;

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (!base_ram_ce_n && !base_ram_we_n && !base_ram_be_n[i])
        bmem[base_ram_addr[3:0]][8*i +: 8] <= base_ram_data[8*i +: 8];
      if (!ext_ram_ce_n && !ext_ram_we_n && !ext_ram_be_n[i])
        emem[ext_ram_addr[3:0]][8*i +: 8] <= ext_ram_data[8*i +: 8];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int passes = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;   // -1: latency not checked
    int          acc;
  } exp_t;
  exp_t sb[$];
  exp_t e;

  // Scoreboard monitor; latency counts the cycle after acceptance as 1.
  always @(negedge clk) begin
    if (rst_n && bus.resp_valid) begin
      if (sb.size() == 0) begin
        checks++;
        $display("FAIL unexpected_resp rdata=%h err=%b", bus.resp_rdata, bus.resp_err);
      end else begin
        e = sb.pop_front();
        checks++;
        if (bus.resp_rdata !== e.rdata)
          $display("FAIL resp_rdata got=%h exp=%h", bus.resp_rdata, e.rdata);
        else passes++;
        checks++;
        if (bus.resp_err !== e.err)
          $display("FAIL resp_err got=%b exp=%b", bus.resp_err, e.err);
        else passes++;
        if (e.lat >= 0) begin
          checks++;
          if (cyc - e.acc + 1 != e.lat)
            $display("FAIL resp_latency got=%0d exp=%0d", cyc - e.acc + 1, e.lat);
          else passes++;
        end
      end
    end else if (rst_n && bus.resp_rdata !== 32'h0) begin
      checks++;
      $display("FAIL idle_rdata got=%h exp=0", bus.resp_rdata);
    end
  end

  // Drive one request; returns just after the acceptance edge with req_*
  // scrambled so any late sampling of the inputs shows up as bad data.
  task automatic issue(input logic we, input logic [31:0] addr, input logic [1:0] size,
                       input logic uns, input logic [31:0] wdata, input logic push,
                       input logic [31:0] er, input logic ee, input int el);
    int n = 0;
    @(negedge clk);
    while (!bus.req_ready && n < 100) begin @(negedge clk); n++; end
    if (!bus.req_ready) begin
      checks++;
      $display("FAIL issue_ready timeout addr=%h", addr);
      return;
    end
    bus.req_we = we; bus.req_addr = addr; bus.req_size = size;
    bus.req_unsigned = uns; bus.req_wdata = wdata; bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.req_we = 1'($urandom); bus.req_addr = $urandom; bus.req_size = 2'($urandom);
    bus.req_unsigned = 1'($urandom); bus.req_wdata = $urandom;
    if (push) sb.push_back('{er, ee, el, cyc});
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || !bus.req_ready) && n < 200) begin @(negedge clk); n++; end
    checks++;
    if (sb.size() != 0 || !bus.req_ready)
      $display("FAIL drain timeout pending=%0d exp=0", sb.size());
    else passes++;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({base_ram_ce_n, base_ram_oe_n, base_ram_we_n, ext_ram_ce_n, ext_ram_oe_n,
         ext_ram_we_n, uart_rdn, uart_wrn} !== 8'hFF)
      $display("FAIL reset_strobes got=%b exp=11111111", {base_ram_ce_n, base_ram_oe_n,
               base_ram_we_n, ext_ram_ce_n, ext_ram_oe_n, ext_ram_we_n, uart_rdn, uart_wrn});
    else passes++;
    checks++;
    if ({base_ram_be_n, ext_ram_be_n} !== 8'hFF)
      $display("FAIL reset_be_n got=%b exp=11111111", {base_ram_be_n, ext_ram_be_n});
    else passes++;
    checks++;
    if ({bus.resp_valid, bus.resp_err, bus.resp_rdata} !== 34'h0)
      $display("FAIL reset_resp got=%b/%b/%h exp=0/0/0", bus.resp_valid, bus.resp_err, bus.resp_rdata);
    else passes++;
    checks++;
    if ({debug_leds, debug_dpys} !== 24'h0)
      $display("FAIL reset_debug got=%h/%h exp=0/0", debug_leds, debug_dpys);
    else passes++;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b1) $display("FAIL reset_ready got=%b exp=1", bus.req_ready);
    else passes++;
  endtask

  task automatic test_ram_write();
    int ce_n = 0, we_n = 0, be_bad = 0, addr_bad = 0, data_bad = 0, other = 0, rcyc = 0;
    issue(1'b1, 32'h8000_0010, 2'b10, 1'b0, 32'hDEAD_BEEF, 1'b1, 32'h0, 1'b0, WAITC + 3);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (!base_ram_ce_n) begin
        ce_n++;
        if (base_ram_be_n !== 4'b0000) be_bad++;
        if (base_ram_addr !== 20'h4) addr_bad++;
      end
      if (!base_ram_we_n) begin
        we_n++;
        if (base_ram_data !== 32'hDEAD_BEEF) data_bad++;
      end
      if (!ext_ram_ce_n || !base_ram_oe_n) other++;
      if (bus.resp_valid && rcyc == 0) rcyc = k;
    end
    checks++;
    if (ce_n != WAITC + 2) $display("FAIL wr_ce_cycles got=%0d exp=%0d", ce_n, WAITC + 2);
    else passes++;
    checks++;
    if (we_n != WAITC + 1) $display("FAIL wr_we_cycles got=%0d exp=%0d", we_n, WAITC + 1);
    else passes++;
    checks++;
    if (be_bad + addr_bad + data_bad + other != 0)
      $display("FAIL wr_pins be=%0d addr=%0d data=%0d other=%0d exp=0", be_bad, addr_bad, data_bad, other);
    else passes++;
    checks++;
    if (rcyc != 4) $display("FAIL wr_resp_cycle got=%0d exp=4", rcyc);
    else passes++;
    checks++;
    if (bmem[4] !== 32'hDEAD_BEEF) $display("FAIL wr_mem got=%h exp=deadbeef", bmem[4]);
    else passes++;
  endtask

  task automatic test_ram_read();
    int ce_n = 0, be_bad = 0, base_act = 0;
    issue(1'b1, 32'h8040_0000, 2'b10, 1'b0, 32'h80FF_FFFF, 1'b1, 32'h0, 1'b0, WAITC + 3);
    issue(1'b0, 32'h8040_0003, 2'b00, 1'b0, 32'h0, 1'b1, 32'hFFFF_FF80, 1'b0, WAITC + 3);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (!ext_ram_ce_n) begin
        ce_n++;
        if (ext_ram_be_n !== 4'b0111) be_bad++;
      end
      if (!base_ram_ce_n) base_act++;
    end
    checks++;
    if (ce_n != WAITC + 2 || be_bad != 0 || base_act != 0)
      $display("FAIL rd_byte_pins ce=%0d be_bad=%0d base=%0d exp=%0d/0/0", ce_n, be_bad, base_act, WAITC + 2);
    else passes++;
    issue(1'b0, 32'h8040_0003, 2'b00, 1'b1, 32'h0, 1'b1, 32'h0000_0080, 1'b0, WAITC + 3);
    issue(1'b0, 32'h8000_0010, 2'b10, 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0, WAITC + 3);
    issue(1'b0, 32'h8000_0012, 2'b01, 1'b0, 32'h0, 1'b1, 32'hFFFF_DEAD, 1'b0, WAITC + 3);
    issue(1'b0, 32'h8000_0010, 2'b01, 1'b1, 32'h0, 1'b1, 32'h0000_BEEF, 1'b0, WAITC + 3);
    issue(1'b0, 32'h8000_0011, 2'b00, 1'b1, 32'h0, 1'b1, 32'h0000_00BE, 1'b0, WAITC + 3);
    issue(1'b1, 32'h8000_0013, 2'b00, 1'b0, 32'h1234_565A, 1'b1, 32'h0, 1'b0, WAITC + 3);
    issue(1'b0, 32'h8000_0010, 2'b10, 1'b0, 32'h0, 1'b1, 32'h5AAD_BEEF, 1'b0, WAITC + 3);
    issue(1'b1, 32'h8040_0002, 2'b01, 1'b0, 32'hABCD_7777, 1'b1, 32'h0, 1'b0, WAITC + 3);
    issue(1'b0, 32'h8040_0000, 2'b10, 1'b0, 32'h0, 1'b1, 32'h7777_FFFF, 1'b0, WAITC + 3);
    drain();
  endtask

  task automatic test_misaligned();
    int act = 0;
    issue(1'b0, 32'h8000_0001, 2'b01, 1'b0, 32'h0, 1'b1, 32'h0, 1'b1, 1);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (!base_ram_ce_n || !ext_ram_ce_n) act++;
    end
    checks++;
    if (act != 0) $display("FAIL misalign_ce got=%0d exp=0", act);
    else passes++;
    issue(1'b0, 32'h8000_0002, 2'b10, 1'b0, 32'h0, 1'b1, 32'h0, 1'b1, 1);
    issue(1'b0, 32'h8000_0000, 2'b11, 1'b0, 32'h0, 1'b1, 32'h0, 1'b1, 1);
    issue(1'b1, 32'h8000_0003, 2'b01, 1'b0, 32'hFFFF_FFFF, 1'b1, 32'h0, 1'b1, 1);
    drain();
    checks++;
    if (bmem[0] !== 32'hxxxx_xxxx && bmem[0] === 32'hFFFF_FFFF)
      $display("FAIL misalign_write_mem got=%h exp=untouched", bmem[0]);
    else passes++;
  endtask

  task automatic test_uart_write();
    int hi = 0, lo = 0, data_bad = 0, ce_act = 0;
    uart_tbre = 1'b0;
    issue(1'b1, 32'hBFD0_03F8, 2'b00, 1'b0, 32'h7766_5541, 1'b1, 32'h0, 1'b0, -1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (uart_wrn) hi++;
    end
    uart_tbre = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (!uart_wrn) begin
        lo++;
        if (base_ram_data[7:0] !== 8'h41) data_bad++;
      end
      if (!base_ram_ce_n) ce_act++;
    end
    checks++;
    if (hi != 5) $display("FAIL uart_wr_wait got=%0d exp=5", hi);
    else passes++;
    checks++;
    if (lo != UPUL) $display("FAIL uart_wr_pulse got=%0d exp=%0d", lo, UPUL);
    else passes++;
    checks++;
    if (data_bad != 0 || ce_act != 0)
      $display("FAIL uart_wr_pins data_bad=%0d ce=%0d exp=0/0", data_bad, ce_act);
    else passes++;
    drain();
  endtask

  task automatic test_uart_read();
    int lo = 0;
    uart_rx = 8'hA5;
    issue(1'b0, 32'hBFD0_03F8, 2'b10, 1'b0, 32'h0, 1'b1, 32'h0000_00A5, 1'b0, UPUL + 1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (!uart_rdn) lo++;
    end
    checks++;
    if (lo != UPUL) $display("FAIL uart_rd_pulse got=%0d exp=%0d", lo, UPUL);
    else passes++;
    uart_dataready = 1'b1; uart_tsre = 1'b0;
    issue(1'b0, 32'hBFD0_03FC, 2'b10, 1'b0, 32'h0, 1'b1, 32'h2, 1'b0, 1);
    drain();
    uart_dataready = 1'b0; uart_tsre = 1'b1;
    issue(1'b0, 32'hBFD0_03FC, 2'b10, 1'b0, 32'h0, 1'b1, 32'h1, 1'b0, 1);
    issue(1'b1, 32'hBFD0_03FC, 2'b10, 1'b0, 32'hFFFF_FFFF, 1'b1, 32'h0, 1'b0, 1);
    drain();
  endtask

  task automatic test_debug_regs();
    issue(1'b1, 32'hBFD0_0400, 2'b10, 1'b0, 32'hFFFF_1234, 1'b1, 32'h0, 1'b0, 1);
    checks++;
    if (debug_leds !== 16'h1234) $display("FAIL led_reg got=%h exp=1234", debug_leds);
    else passes++;
    issue(1'b0, 32'hBFD0_0400, 2'b10, 1'b0, 32'h0, 1'b1, 32'h0000_1234, 1'b0, 1);
    issue(1'b1, 32'hBFD0_0408, 2'b10, 1'b0, 32'h0000_AB5C, 1'b1, 32'h0, 1'b0, 1);
    checks++;
    if (debug_dpys !== 8'h5C) $display("FAIL dpy_reg got=%h exp=5c", debug_dpys);
    else passes++;
    issue(1'b0, 32'hBFD0_0408, 2'b10, 1'b0, 32'h0, 1'b1, 32'h0000_005C, 1'b0, 1);
    drain();
  endtask

  task automatic test_back_to_back();
    logic [31:0] vals [8];
    for (int i = 0; i < 8; i++) begin
      vals[i] = $urandom;
      issue(1'b1, 32'h8000_0000 | (32'(i & 1) << 22) | (32'(8 + i) << 2), 2'b10, 1'b0,
            vals[i], 1'b1, 32'h0, 1'b0, WAITC + 3);
    end
    for (int i = 0; i < 8; i++)
      issue(1'b0, 32'h8000_0000 | (32'(i & 1) << 22) | (32'(8 + i) << 2), 2'b10, 1'b0,
            32'h0, 1'b1, vals[i], 1'b0, WAITC + 3);
    drain();
  endtask

  task automatic test_reset_mid();
    int n = 0, resp = 0;
    issue(1'b1, 32'hBFD0_0400, 2'b10, 1'b0, 32'h0000_FFFF, 1'b1, 32'h0, 1'b0, 1);
    drain();
    issue(1'b0, 32'h8000_0010, 2'b10, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, -1);
    while (base_ram_oe_n && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (base_ram_oe_n !== 1'b0) $display("FAIL rstmid_reach_strobe got=%b exp=0", base_ram_oe_n);
    else passes++;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({base_ram_ce_n, base_ram_oe_n, base_ram_we_n, base_ram_be_n} !== 7'h7F)
      $display("FAIL rstmid_strobes got=%b exp=1111111",
               {base_ram_ce_n, base_ram_oe_n, base_ram_we_n, base_ram_be_n});
    else passes++;
    checks++;
    if (debug_leds !== 16'h0) $display("FAIL rstmid_leds got=%h exp=0", debug_leds);
    else passes++;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b1) $display("FAIL rstmid_ready got=%b exp=1", bus.req_ready);
    else passes++;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (bus.resp_valid) resp++;
    end
    checks++;
    if (resp != 0) $display("FAIL rstmid_no_resp got=%0d exp=0", resp);
    else passes++;
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0;
    bus.req_size = '0; bus.req_unsigned = 1'b0; bus.req_wdata = '0;
    test_reset();
    test_ram_write();
    test_ram_read();
    test_misaligned();
    test_uart_write();
    test_uart_read();
    test_debug_regs();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
